// File: rtl/window_frame_sequencer.sv
// rtl/window_frame_sequencer.sv - downsampled-domain frame sequencer for the 5x5 window path
module window_frame_sequencer #(
  parameter int COLS         = 400,
  parameter int ROWS         = 300,
  parameter int BORDER       = 2,
  parameter int FLUSH_CYCLES = 804
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       valid_in,
  input  logic       blank_in,
  input  logic       clear_err,
  output logic [9:0] rowcount,
  output logic [9:0] colcount,
  output logic       center_valid,
  output logic [9:0] center_row,
  output logic [9:0] center_col,
  output logic       flush,
  output logic       frame_done,
  output logic       busy,
  output logic       overrun,
  output logic       row_error
);

  typedef enum logic [1:0] {S_WAIT_SOF, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  localparam logic [9:0]  COLS_M1    = 10'(COLS - 1);
  localparam logic [9:0]  ROWS_M1    = 10'(ROWS - 1);
  localparam logic [9:0]  ROWS_W     = 10'(ROWS);
  localparam logic [9:0]  BRD        = 10'(BORDER);
  localparam logic [9:0]  BRD2       = 10'(2 * BORDER);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

  state_t      state_q;
  logic [9:0]  row_q, col_q;
  logic [15:0] fcnt_q;
  logic [9:0]  rowcount_q, colcount_q, center_row_q, center_col_q;
  logic        center_valid_q, flush_q, frame_done_q, busy_q, overrun_q, row_error_q;

  logic       accept, short_row, col_wrap, last_pix, centre_ok;
  logic [9:0] col_nx, row_nx;

  assign accept    = valid_in && !blank_in;
  assign short_row = valid_in && blank_in && (col_q != 10'd0);
  assign col_wrap  = (col_q == COLS_M1);
  assign col_nx    = col_wrap ? 10'd0 : col_q + 10'd1;
  assign row_nx    = col_wrap ? row_q + 10'd1 : row_q;
  assign last_pix  = (row_q == ROWS_M1) && col_wrap;
  // During flush the pointer runs past the frame; only centres that land inside it count.
  assign centre_ok = (row_q >= BRD2) && (col_q >= BRD2) && ((row_q - BRD) < ROWS_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_WAIT_SOF;
      row_q          <= '0;
      col_q          <= '0;
      fcnt_q         <= '0;
      rowcount_q     <= '0;
      colcount_q     <= '0;
      center_row_q   <= '0;
      center_col_q   <= '0;
      center_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      row_error_q    <= 1'b0;
    end else begin
      center_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      if (clear_err) begin
        overrun_q   <= 1'b0;
        row_error_q <= 1'b0;
      end
      case (state_q)
        S_WAIT_SOF, S_ACTIVE: begin
          // Pointers are zero in WAIT_SOF, so the first pixel steps exactly like any other.
          if (accept && (enable || state_q == S_ACTIVE)) begin
            rowcount_q     <= row_q;
            colcount_q     <= col_q;
            center_row_q   <= row_q - BRD;
            center_col_q   <= col_q - BRD;
            center_valid_q <= centre_ok;
            col_q          <= col_nx;
            row_q          <= row_nx;
            busy_q         <= 1'b1;
            if (last_pix) begin
              state_q <= S_FLUSH;
              fcnt_q  <= '0;
            end else begin
              state_q <= S_ACTIVE;
            end
          end else if (state_q == S_ACTIVE && short_row) begin
            row_error_q <= 1'b1;
            col_q       <= '0;
            row_q       <= row_q + 10'd1;
            if (row_q == ROWS_M1) begin
              state_q <= S_FLUSH;
              fcnt_q  <= '0;
            end
          end
        end
        S_FLUSH: begin
          flush_q        <= 1'b1;
          rowcount_q     <= row_q;
          colcount_q     <= col_q;
          center_row_q   <= row_q - BRD;
          center_col_q   <= col_q - BRD;
          center_valid_q <= centre_ok;
          col_q          <= col_nx;
          row_q          <= row_nx;
          fcnt_q         <= fcnt_q + 16'd1;
          if (accept) overrun_q <= 1'b1;
          if (fcnt_q == FLUSH_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          frame_done_q <= 1'b1;
          row_q        <= '0;
          col_q        <= '0;
          state_q      <= S_WAIT_SOF;
          if (accept) overrun_q <= 1'b1;
        end
      endcase
    end
  end

  assign rowcount     = rowcount_q;
  assign colcount     = colcount_q;
  assign center_valid = center_valid_q;
  assign center_row   = center_row_q;
  assign center_col   = center_col_q;
  assign flush        = flush_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign row_error    = row_error_q;

endmodule

// File: tb/tb_window_frame_sequencer.sv
// tb/tb_window_frame_sequencer.sv - bench for window_frame_sequencer against a linear-index reference model
module tb_window_frame_sequencer;
  localparam int COLS   = 8;
  localparam int ROWS   = 6;
  localparam int BORDER = 2;
  localparam int FLUSH  = BORDER * COLS + BORDER * 2;
  localparam int NPIX   = COLS * ROWS;

  logic clock = 1'b0;
  logic reset, enable, valid_in, blank_in, clear_err;
  logic [9:0] rowcount, colcount, center_row, center_col;
  logic center_valid, flush, frame_done, busy, overrun, row_error;

  always #5 clock = ~clock;

  window_frame_sequencer #(.COLS(COLS), .ROWS(ROWS), .BORDER(BORDER), .FLUSH_CYCLES(FLUSH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .valid_in(valid_in), .blank_in(blank_in),
    .clear_err(clear_err), .rowcount(rowcount), .colcount(colcount), .center_valid(center_valid),
    .center_row(center_row), .center_col(center_col), .flush(flush), .frame_done(frame_done),
    .busy(busy), .overrun(overrun), .row_error(row_error)
  );

  int checks = 0;
  int errors = 0;

  // Model: position is a linear index into the frame (virtual beyond it during flush).
  int m_mode, m_idx, m_fl;
  bit m_ovr, m_rerr;
  int e_row, e_col;
  bit e_cv, e_fl, e_done, e_busy;

  int n_cv, n_fl, n_done;
  bit seen_cv;
  int first_r, first_c, first_cr, first_cc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic void emit(input int i);
    e_row = i / COLS;
    e_col = i % COLS;
    e_cv  = (e_row >= 2 * BORDER) && (e_col >= 2 * BORDER) && (e_row - BORDER < ROWS);
  endfunction

  function automatic void model(input bit v, input bit b, input bit en, input bit clr);
    bit acc;
    acc    = v && !b;
    e_cv   = 1'b0;
    e_fl   = 1'b0;
    e_done = 1'b0;
    if (clr) begin
      m_ovr  = 1'b0;
      m_rerr = 1'b0;
    end
    case (m_mode)
      0: if (acc && en) begin
        emit(0);
        m_idx  = 1;
        e_busy = 1'b1;
        m_fl   = 0;
        m_mode = (m_idx == NPIX) ? 2 : 1;
      end
      1: if (acc) begin
        emit(m_idx);
        m_idx++;
        if (m_idx == NPIX) begin m_mode = 2; m_fl = 0; end
      end else if (v && b && (m_idx % COLS) != 0) begin
        m_rerr = 1'b1;
        m_idx  = (m_idx / COLS + 1) * COLS;
        if (m_idx >= NPIX) begin m_mode = 2; m_fl = 0; end
      end
      2: begin
        if (acc) m_ovr = 1'b1;
        e_fl = 1'b1;
        emit(m_idx);
        m_idx++;
        m_fl++;
        if (m_fl == FLUSH) begin m_mode = 3; e_busy = 1'b0; end
      end
      default: begin
        if (acc) m_ovr = 1'b1;
        e_done = 1'b1;
        m_mode = 0;
      end
    endcase
  endfunction

  task automatic check_outputs();
    chk("rowcount", 32'(rowcount), 32'(e_row));
    chk("colcount", 32'(colcount), 32'(e_col));
    chk("center_valid", 32'(center_valid), 32'(e_cv));
    if (e_cv) begin
      chk("center_row", 32'(center_row), 32'(e_row - BORDER));
      chk("center_col", 32'(center_col), 32'(e_col - BORDER));
    end
    chk("flush", 32'(flush), 32'(e_fl));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("row_error", 32'(row_error), 32'(m_rerr));
  endtask

  task automatic step(input bit v, input bit b, input bit clr = 1'b0);
    valid_in  = v;
    blank_in  = b;
    clear_err = clr;
    @(posedge clock);
    #1;
    model(v, b, enable, clr);
    check_outputs();
    n_cv   += int'(center_valid);
    n_fl   += int'(flush);
    n_done += int'(frame_done);
    if (center_valid && !seen_cv) begin
      seen_cv  = 1'b1;
      first_r  = int'(rowcount);
      first_c  = int'(colcount);
      first_cr = int'(center_row);
      first_cc = int'(center_col);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; blank_in = 1'b0; clear_err = 1'b0;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    m_mode = 0; m_idx = 0; m_fl = 0; m_ovr = 1'b0; m_rerr = 1'b0;
    e_row = 0; e_col = 0; e_cv = 1'b0; e_fl = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    check_outputs();
  endtask

  task automatic clr_stats();
    n_cv = 0; n_fl = 0; n_done = 0; seen_cv = 1'b0;
    first_r = -1; first_c = -1; first_cr = -1; first_cc = -1;
  endtask

  initial begin
    enable = 1'b1;
    clr_stats();
    do_reset();

    // Back-to-back frame: last pixel, flush length, centre count, first centre.
    for (int p = 0; p < NPIX; p++) step(1'b1, 1'b0);
    chk("t1_last_row", 32'(rowcount), 32'd5);
    chk("t1_last_col", 32'(colcount), 32'd7);
    repeat (FLUSH + 4) step(1'b0, 1'b0);
    chk("t1_flush_len", 32'(n_fl), 32'(FLUSH));
    chk("t1_done_cnt", 32'(n_done), 32'd1);
    chk("t2_centres", 32'(n_cv), 32'd16);
    chk("t2_first_row", 32'(first_r), 32'd4);
    chk("t2_first_col", 32'(first_c), 32'd4);
    chk("t2_first_crow", 32'(first_cr), 32'd2);
    chk("t2_first_ccol", 32'(first_cc), 32'd2);

    // Random idle gaps inside rows and blank beats only at row boundaries.
    clr_stats();
    for (int p = 0; p < NPIX; p++) begin
      if (p % COLS == 0 && p > 0) repeat ($urandom_range(0, 3)) step(1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom % 2));
      step(1'b1, 1'b0);
    end
    repeat (FLUSH + 4) step(1'b0, 1'b0);
    chk("t3_flush_len", 32'(n_fl), 32'(FLUSH));
    chk("t3_done_cnt", 32'(n_done), 32'd1);
    chk("t3_centres", 32'(n_cv), 32'd16);
    chk("t3_row_error", 32'(row_error), 32'd0);

    // Short row at col 3 of row 2, resync to (3,0), then clear.
    repeat (2 * COLS + 3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t4_row_error_set", 32'(row_error), 32'd1);
    step(1'b1, 1'b0);
    chk("t4_resync_row", 32'(rowcount), 32'd3);
    chk("t4_resync_col", 32'(colcount), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_row_error_clr", 32'(row_error), 32'd0);
    for (int i = 0; i < 4 * NPIX && m_mode == 1; i++) step(1'b1, 1'b0);
    repeat (FLUSH + 4) step(1'b0, 1'b0);

    // Pixel during flush; clear_err colliding with a new overrun keeps it set.
    clr_stats();
    for (int p = 0; p < NPIX; p++) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_set_wins", 32'(overrun), 32'd1);
    repeat (FLUSH) step(1'b0, 1'b0);
    chk("t5_flush_len", 32'(n_fl), 32'(FLUSH));
    chk("t5_done_cnt", 32'(n_done), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_overrun_clr", 32'(overrun), 32'd0);
    step(1'b1, 1'b0);
    chk("t5_next_row", 32'(rowcount), 32'd0);
    chk("t5_next_col", 32'(colcount), 32'd0);
    chk("t5_next_busy", 32'(busy), 32'd1);

    // Reset mid-frame at row 3, pixels ignored while disabled, restart at (0,0).
    repeat (3 * COLS + 1) step(1'b1, 1'b0);
    chk("t6_pre_row", 32'(rowcount), 32'd3);
    do_reset();
    clr_stats();
    enable = 1'b0;
    repeat (5) step(1'b1, 1'b0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    repeat (FLUSH + 4) step(1'b0, 1'b0);
    chk("t6_no_done", 32'(n_done), 32'd0);
    enable = 1'b1;
    step(1'b1, 1'b0);
    chk("t6_restart_row", 32'(rowcount), 32'd0);
    chk("t6_restart_col", 32'(colcount), 32'd0);
    for (int i = 0; i < 4 * NPIX && m_mode == 1; i++) step(1'b1, 1'b0);
    repeat (FLUSH + 4) step(1'b0, 1'b0);

    // Free-running random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom % 8) != 0;
      step(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 40) == 0);
    end
    enable = 1'b1;
    repeat (FLUSH + 4) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
